// File: rtl/accum_mult_arb.sv
// Round-robin arbiter sharing one external multiplier among NUM_REQ requesters.
// One operation in flight: accept, issue, wait for product, return to requester.
module accum_mult_arb #(
  parameter int NUM_REQ = 4,
  parameter int BITS_A  = 256,
  parameter int BITS_B  = BITS_A
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [NUM_REQ*BITS_A-1:0]   i_dat_a,
  input  logic [NUM_REQ*BITS_B-1:0]   i_dat_b,
  input  logic [NUM_REQ-1:0]          i_val,
  output logic [NUM_REQ-1:0]          o_rdy,
  output logic [BITS_A+BITS_B-1:0]    o_dat,
  output logic [NUM_REQ-1:0]          o_val,
  input  logic [NUM_REQ-1:0]          i_rdy,
  output logic [BITS_A-1:0]           o_mul_dat_a,
  output logic [BITS_B-1:0]           o_mul_dat_b,
  output logic                        o_mul_val,
  input  logic                        i_mul_rdy,
  input  logic [BITS_A+BITS_B-1:0]    i_mul_dat,
  input  logic                        i_mul_val,
  output logic                        o_mul_rdy,
  output logic [31:0]                 o_op_cnt
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW = BITS_A + BITS_B;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RETURN
  } state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [GW-1:0]     last_q, last_d;
  logic [BITS_A-1:0] a_q, a_d;
  logic [BITS_B-1:0] b_q, b_d;
  logic [PW-1:0]     dat_q, dat_d;
  logic [31:0]       cnt_q, cnt_d;
  logic              en_q;
  logic [GW-1:0]     win;
  logic              win_vld;
  logic [GW:0]       idx;

  // Accept gate: held low through reset and until the first edge after release
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) en_q <= 1'b0;
    else          en_q <= 1'b1;
  end

  // Round-robin winner search starting just after the last served requester
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    idx     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (GW+1)'(last_q) + (GW+1)'(i);
      if (idx >= (GW+1)'(NUM_REQ))
        idx = idx - (GW+1)'(NUM_REQ);
      if (!win_vld && i_val[idx[GW-1:0]]) begin
        win_vld = 1'b1;
        win     = idx[GW-1:0];
      end
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    a_d       = a_q;
    b_d       = b_q;
    dat_d     = dat_q;
    cnt_d     = cnt_q;
    o_rdy     = '0;
    o_val     = '0;
    o_mul_val = 1'b0;
    o_mul_rdy = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (en_q && win_vld) begin
          o_rdy[win] = 1'b1;
          a_d        = i_dat_a[win*BITS_A +: BITS_A];
          b_d        = i_dat_b[win*BITS_B +: BITS_B];
          grant_d    = win;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        o_mul_val = 1'b1;
        if (i_mul_rdy) state_d = S_WAIT;
      end
      S_WAIT: begin
        o_mul_rdy = 1'b1;
        if (i_mul_val) begin
          dat_d   = i_mul_dat;
          state_d = S_RETURN;
        end
      end
      S_RETURN: begin
        o_val[grant_q] = 1'b1;
        if (i_rdy[grant_q]) begin
          last_d  = grant_q;
          cnt_d   = cnt_q + 32'd1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      last_q  <= GW'(NUM_REQ - 1);
      a_q     <= '0;
      b_q     <= '0;
      dat_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dat_q   <= dat_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_mul_dat_a = a_q;
  assign o_mul_dat_b = b_q;
  assign o_dat       = dat_q;
  assign o_op_cnt    = cnt_q;

endmodule

// File: doc/accum_mult_arb.md
ACCUM_MULT_ARB -- requirements
Module: accum_mult_arb

Interface
REQ-001 SHALL provide parameter NUM_REQ, default 4: number of requesters sharing one multiplier, minimum 2.
REQ-002 SHALL provide parameter BITS_A, default 256: operand A width.
REQ-003 SHALL provide parameter BITS_B, default BITS_A: operand B width.
REQ-004 SHALL provide port i_clk  in  1: single clock; all logic is rising-edge.
REQ-005 SHALL provide port i_rst_n  in  1: asynchronous, active-low reset.
REQ-006 SHALL provide port i_dat_a  in  NUM_REQ*BITS_A: per-requester operand A; requester k occupies slice k.
REQ-007 SHALL provide port i_dat_b  in  NUM_REQ*BITS_B: per-requester operand B; requester k occupies slice k.
REQ-008 SHALL provide port i_val  in  NUM_REQ: per-requester request valid.
REQ-009 SHALL provide port o_rdy  out  NUM_REQ: per-requester request accept, one-hot or zero.
REQ-010 SHALL provide port o_dat  out  BITS_A+BITS_B: product returned to the granted requester.
REQ-011 SHALL provide port o_val  out  NUM_REQ: per-requester result valid, one-hot or zero.
REQ-012 SHALL provide port i_rdy  in  NUM_REQ: per-requester result ready.
REQ-013 SHALL provide port o_mul_dat_a / o_mul_dat_b  out  BITS_A / BITS_B: operands to the multiplier.
REQ-014 SHALL provide port o_mul_val  out  1 and i_mul_rdy  in  1: multiplier request handshake.
REQ-015 SHALL provide port i_mul_dat  in  BITS_A+BITS_B, i_mul_val  in  1, o_mul_rdy  out  1: multiplier result handshake.
REQ-016 SHALL provide port o_op_cnt  out  32: count of completed operations.

Function
REQ-017 SHALL implement states IDLE, ISSUE, WAIT, RETURN, with exactly one operation outstanding at a time.
REQ-018 In IDLE, the winner SHALL be the first k with i_val[k]=1, searching round-robin from (last_grant+1) mod NUM_REQ; the winner is combinational.
REQ-019 In IDLE, o_rdy[winner] SHALL be 1 combinationally; all other o_rdy bits SHALL be 0; o_rdy SHALL be all-zero outside IDLE or when no i_val bit is set.
REQ-020 On an accept (o_rdy[k]&i_val[k]), the block SHALL register operands k, set grant=k and go to ISSUE on the next edge.
REQ-021 In ISSUE, o_mul_val SHALL be 1 and o_mul_dat_a/b SHALL equal the latched operands; on i_mul_rdy=1 the state SHALL go to WAIT.
REQ-022 In WAIT, o_mul_rdy SHALL be 1; on i_mul_val=1, i_mul_dat SHALL be registered into o_dat and the state SHALL go to RETURN. o_mul_rdy SHALL be 0 in all other states.
REQ-023 In RETURN, o_val[grant] SHALL be 1 and o_dat SHALL be held stable until i_rdy[grant]=1; i_rdy bits of other requesters SHALL be ignored.
REQ-024 On o_val[grant]&i_rdy[grant], the block SHALL set last_grant=grant, increment o_op_cnt (wrapping 0xFFFFFFFF->0) and return to IDLE in the same edge.
REQ-025 Minimum request-accept to o_val latency SHALL be 3 cycles plus multiplier latency; after a result handshake, the next accept SHALL be possible on the following cycle.
REQ-026 A requester dropping i_val before accept SHALL lose no state; i_val/i_dat changes after accept SHALL not affect the in-flight operation.
REQ-027 i_mul_val asserted outside WAIT SHALL be ignored; o_val SHALL never assert for more than one requester.
REQ-028 With all NUM_REQ requesters continuously valid, grants SHALL rotate 0,1,...,NUM_REQ-1,0 with no requester starved.

Reset
REQ-029 On i_rst_n=0, the block SHALL immediately force state=IDLE, o_rdy=0 (registered gating), o_val=0, o_mul_val=0, o_mul_rdy=0, o_dat=0, o_op_cnt=0, grant=0 and last_grant=NUM_REQ-1, regardless of state.
REQ-030 Reset mid-operation SHALL discard the in-flight operation with no result delivered; the multiplier SHALL be reset by the same reset.
REQ-031 After reset release, the first accept SHALL occur no earlier than the first rising edge with i_rst_n=1.

Verification
REQ-032 Single request: i_val=4'b0001, A=3, B=5, multiplier returns 15 -> o_rdy[0] pulse, o_val=4'b0001, o_dat=15, o_op_cnt=1.
REQ-033 All four valid continuously for 8 ops -> grant order 0,1,2,3,0,1,2,3; o_op_cnt=8.
REQ-034 Backpressure: i_rdy[2]=0 for 10 cycles in RETURN -> o_val[2] and o_dat held stable, no new accept, o_mul_rdy=0.
REQ-035 Mixed valid: i_val=4'b1010 after last_grant=1 -> grant 3, then 1.
REQ-036 Reset asserted in WAIT -> all outputs zero asynchronously; after release, request 0 is granted first, with no stale o_val.
REQ-037 Spurious i_mul_val in IDLE and ISSUE -> no state change and o_dat unchanged.
